vram_dma: RTL and testbench
===========================

VRAM_DMA -- requirements
Module: vram_dma

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of write-queue entries (power of two, 2..16).
REQ-002 SHALL have port i_clk, input, 1, the 25.175 MHz pixel clock shared with the VGA generator.
REQ-003 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports i_ctrl_ce_b, i_ctrl_w_b, i_ctrl_addr, i_ctrl_data: inputs of width 1/1/2/8, forming the asynchronous CPU write interface.
REQ-005 SHALL have port i_free_vbus_b, input, 1; low means the VRAM bus is free for DMA.
REQ-006 SHALL have ports o_vaddr (16), o_vdata (8), o_vwe_b (1), o_vbus_en_b (1) as outputs: VRAM address, VRAM data, write strobe, and bus-drive enable.
REQ-007 SHALL have ports o_fifo_full_b, o_idle_b, o_overflow: outputs of width 1 each, giving queue full, queue empty with FSM idle, and the sticky overflow flag.

Function
REQ-008 SHALL synchronise i_ctrl_w_b through 2 flip-flops, then detect its falling edge; an access is accepted when the edge occurs while i_ctrl_ce_b is low, with addr/data captured at the edge cycle.
REQ-009 Register map SHALL be: 0 = pointer[7:0]; 1 = pointer[15:8]; 2 = push {pointer, data} into the queue; 3 = write 1 to bit0 clears o_overflow, write 1 to bit1 flushes the queue.
REQ-010 A push to a full queue SHALL be dropped, set o_overflow, and leave the pointer unchanged.
REQ-011 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, each lasting exactly 1 clock.
REQ-012 IDLE->SETUP SHALL occur when the queue is non-empty and i_free_vbus_b=0 at the clock edge; the queue head is popped into the output registers on that edge.
REQ-013 In SETUP, o_vbus_en_b=0, o_vaddr/o_vdata=entry, and o_vwe_b=1.
REQ-014 In STROBE, o_vwe_b=0 and the other outputs are unchanged.
REQ-015 In HOLD, o_vwe_b=1, the bus is still driven, then the FSM returns to IDLE.
REQ-016 A started cycle SHALL complete even if i_free_vbus_b rises mid-cycle; the upstream window guard covers 3 clocks.
REQ-017 Back-to-back: after HOLD the FSM passes through IDLE for 1 clock, so the minimum period is 4 clocks per byte.
REQ-018 In IDLE, o_vbus_en_b=1 and o_vwe_b=1; o_vaddr and o_vdata hold their last values.
REQ-019 Simultaneous push and pop SHALL be allowed; the count stays unchanged, and a push on a full queue in the same cycle as a pop is accepted.
REQ-020 A flush SHALL empty the queue immediately; an in-flight cycle completes.
REQ-021 Pointer arithmetic SHALL be 16-bit and wrap from 0xFFFF to 0x0000.
REQ-022 o_idle_b SHALL be 0 only when the queue is empty and the FSM is in IDLE.
REQ-023 o_fifo_full_b SHALL be 0 while count==FIFO_DEPTH.

Reset
REQ-024 While i_rst=1, the FSM SHALL be in IDLE, the queue empty, pointer=0, o_overflow=0, o_vwe_b=1, o_vbus_en_b=1, o_vaddr=0, o_vdata=0, and the synchronisers set to 1 (no false edge).
REQ-025 Reset asserted mid-cycle SHALL release the bus asynchronously within the reset propagation time; the in-flight write is abandoned.

Configuration
REQ-026 With VRAM_DMA_AUTOINC_EN defined, each accepted push SHALL increment the pointer by 1 (wrapping).
REQ-027 Without VRAM_DMA_AUTOINC_EN, the pointer SHALL change only on writes to registers 0 and 1.

Structure
REQ-028 Package vram_dma_pkg SHALL hold the FSM state enum, the register address constants, and the queue entry typedef {addr16, data8}.
REQ-029 The queue SHALL be a sub-module vram_dma_fifo (synchronous, registered count, no first-word fall-through requirement beyond a 1-cycle pop).

Verification
REQ-030 Pointer=0x1234, push 0xAA, i_free_vbus_b=0 -> within 4 clk of edge detect, o_vaddr=0x1234, o_vdata=0xAA, o_vwe_b low for exactly 1 clk.
REQ-031 AUTOINC on, pointer=0xFFFF, push 0x01 then 0x02 -> writes go to 0xFFFF then 0x0000; pointer ends at 0x0001.
REQ-032 i_free_vbus_b=1, push 5 bytes (depth 4) -> o_fifo_full_b=0, o_overflow=1, no VRAM strobe; release bus -> exactly 4 writes at 4-clk spacing, then o_idle_b=0.
REQ-033 i_free_vbus_b rises during STROBE -> HOLD completes, no new cycle starts until i_free_vbus_b=0 again.
REQ-034 Assert i_rst during STROBE -> o_vwe_b=1 and o_vbus_en_b=1 immediately, queue empty, and no write after release.
REQ-035 Write 0x03 to register 3 with 2 entries queued and overflow set -> queue empty and o_overflow=0 on the next clock.

Source files
------------

// File: rtl/vram_dma_pkg.sv
// Shared definitions for the VRAM DMA block.
//   state_e   - write-cycle FSM states (IDLE, SETUP, STROBE, HOLD)
//   Reg*      - CPU register addresses
//   entry_t   - one queued VRAM write: {addr[15:0], data[7:0]}
package vram_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  localparam logic [1:0] RegPtrLo = 2'd0;
  localparam logic [1:0] RegPtrHi = 2'd1;
  localparam logic [1:0] RegPush  = 2'd2;
  localparam logic [1:0] RegCtrl  = 2'd3;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

endpackage

// File: rtl/vram_dma_fifo.sv
// Synchronous write queue for the VRAM DMA.
// Parameters:
//   FIFO_DEPTH - number of entries, power of two (2..16)
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - discard all entries this cycle (takes priority over push/pop)
//   push, wdata - enqueue wdata (ignored when full unless popping in the same cycle)
//   pop, rdata - dequeue; rdata is the current head, valid whenever not empty
//   empty, full - derived from the registered entry count
module vram_dma_fifo
  import vram_dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || (pop && !empty)) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_dma.sv
// VRAM DMA: takes byte writes from an asynchronous CPU port, queues {pointer, data}
// entries and replays them onto the shared VRAM bus whenever the video side frees it.
// Optional feature macro: VRAM_DMA_AUTOINC_EN - pointer increments after each accepted push.
// Ports:
//   i_clk, i_rst        - pixel clock, asynchronous active-high reset
//   i_ctrl_ce_b/w_b     - CPU chip enable / write strobe (active low, asynchronous)
//   i_ctrl_addr/data    - CPU register address (2b) and write data (8b)
//   i_free_vbus_b       - low when the VRAM bus may be used for DMA
//   o_vaddr/o_vdata     - VRAM address and data
//   o_vwe_b/o_vbus_en_b - VRAM write strobe and bus-drive enable (active low)
//   o_fifo_full_b       - low while the queue is full
//   o_idle_b            - low when the queue is empty and no cycle is in flight
//   o_overflow          - sticky: a push was dropped on a full queue
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ctrl_ce_b,
  input  logic        i_ctrl_w_b,
  input  logic [1:0]  i_ctrl_addr,
  input  logic [7:0]  i_ctrl_data,
  input  logic        i_free_vbus_b,
  output logic [15:0] o_vaddr,
  output logic [7:0]  o_vdata,
  output logic        o_vwe_b,
  output logic        o_vbus_en_b,
  output logic        o_fifo_full_b,
  output logic        o_idle_b,
  output logic        o_overflow
);

  logic        w_meta_q, w_sync_q, w_prev_q;
  logic        access;
  logic        push_req, push_ok, flush, pop_en;
  logic [15:0] ptr_q;
  logic        overflow_q;
  logic        fifo_empty, fifo_full;
  entry_t      head;
  state_e      state_q, state_d;
  logic [15:0] vaddr_q;
  logic [7:0]  vdata_q;
  logic        vwe_b_q, vbus_en_b_q;

  // Write strobe synchroniser; resets high so reset release never looks like an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_meta_q <= 1'b1;
      w_sync_q <= 1'b1;
      w_prev_q <= 1'b1;
    end else begin
      w_meta_q <= i_ctrl_w_b;
      w_sync_q <= w_meta_q;
      w_prev_q <= w_sync_q;
    end
  end

  assign access   = w_prev_q && !w_sync_q && !i_ctrl_ce_b;
  assign push_req = access && (i_ctrl_addr == RegPush);
  assign flush    = access && (i_ctrl_addr == RegCtrl) && i_ctrl_data[1];
  assign pop_en   = (state_q == StIdle) && !fifo_empty && !i_free_vbus_b;
  assign push_ok  = push_req && (!fifo_full || pop_en);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      if (access && (i_ctrl_addr == RegPtrLo)) ptr_q[7:0]  <= i_ctrl_data;
      if (access && (i_ctrl_addr == RegPtrHi)) ptr_q[15:8] <= i_ctrl_data;
`ifdef VRAM_DMA_AUTOINC_EN
      if (push_ok) ptr_q <= ptr_q + 16'd1;
`endif
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (access && (i_ctrl_addr == RegCtrl) && i_ctrl_data[0]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  vram_dma_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .flush(flush),
    .push (push_ok),
    .wdata({ptr_q, i_ctrl_data}),
    .pop  (pop_en),
    .rdata(head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Once started, a cycle always runs SETUP/STROBE/HOLD regardless of i_free_vbus_b.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pop_en) state_d = StSetup;
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bus controls are registered from the next state so the strobe is glitch-free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vaddr_q     <= 16'h0000;
      vdata_q     <= 8'h00;
      vwe_b_q     <= 1'b1;
      vbus_en_b_q <= 1'b1;
    end else begin
      if (pop_en) begin
        vaddr_q <= head.addr;
        vdata_q <= head.data;
      end
      vwe_b_q     <= (state_d != StStrobe);
      vbus_en_b_q <= (state_d == StIdle);
    end
  end

  assign o_vaddr       = vaddr_q;
  assign o_vdata       = vdata_q;
  assign o_vwe_b       = vwe_b_q;
  assign o_vbus_en_b   = vbus_en_b_q;
  assign o_fifo_full_b = !fifo_full;
  assign o_idle_b      = !(fifo_empty && (state_q == StIdle));
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: CPU register writes, VRAM cycle timing, overflow,
// bus release mid-cycle, asynchronous reset mid-cycle and flush.
module tb_vram_dma;

`ifdef VRAM_DMA_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ctrl_ce_b = 1'b1;
  logic        i_ctrl_w_b = 1'b1;
  logic [1:0]  i_ctrl_addr = 2'd0;
  logic [7:0]  i_ctrl_data = 8'h00;
  logic        i_free_vbus_b = 1'b1;
  logic [15:0] o_vaddr;
  logic [7:0]  o_vdata;
  logic        o_vwe_b, o_vbus_en_b, o_fifo_full_b, o_idle_b, o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Strobe log: one entry per clock during which o_vwe_b is low.
  logic [15:0] s_addr[$];
  logic [7:0]  s_data[$];
  int          s_cyc[$];
  logic        s_en[$];

  vram_dma #(.FIFO_DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ctrl_ce_b  (i_ctrl_ce_b),
    .i_ctrl_w_b   (i_ctrl_w_b),
    .i_ctrl_addr  (i_ctrl_addr),
    .i_ctrl_data  (i_ctrl_data),
    .i_free_vbus_b(i_free_vbus_b),
    .o_vaddr      (o_vaddr),
    .o_vdata      (o_vdata),
    .o_vwe_b      (o_vwe_b),
    .o_vbus_en_b  (o_vbus_en_b),
    .o_fifo_full_b(o_fifo_full_b),
    .o_idle_b     (o_idle_b),
    .o_overflow   (o_overflow)
  );

  always #20 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst && !o_vwe_b) begin
      s_addr.push_back(o_vaddr);
      s_data.push_back(o_vdata);
      s_cyc.push_back(cyc);
      s_en.push_back(o_vbus_en_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One CPU write; c0 is the cycle number at which the write strobe went low.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, output int c0);
    step(1);
    i_ctrl_ce_b = 1'b0;
    i_ctrl_addr = a;
    i_ctrl_data = d;
    i_ctrl_w_b  = 1'b0;
    c0 = cyc;
    step(4);
    i_ctrl_w_b  = 1'b1;
    i_ctrl_ce_b = 1'b1;
    step(3);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    int n0;
    step(2);
    checks++; if (o_vwe_b !== 1'b1) begin errors++; $display("FAIL reset_vwe_b: got %b want 1", o_vwe_b); end
    checks++; if (o_vbus_en_b !== 1'b1) begin errors++; $display("FAIL reset_vbus_en_b: got %b want 1", o_vbus_en_b); end
    checks++; if (o_vaddr !== 16'h0000) begin errors++; $display("FAIL reset_vaddr: got %h want 0000", o_vaddr); end
    checks++; if (o_vdata !== 8'h00) begin errors++; $display("FAIL reset_vdata: got %h want 00", o_vdata); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    checks++; if (o_fifo_full_b !== 1'b1) begin errors++; $display("FAIL reset_full_b: got %b want 1", o_fifo_full_b); end
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL reset_idle_b: got %b want 0", o_idle_b); end
    n0 = s_addr.size();
    i_free_vbus_b = 1'b0;
    i_rst = 1'b0;
    step(8);
    checks++; if (s_addr.size() - n0 !== 0) begin errors++; $display("FAIL reset_no_write: got %0d strobes want 0", s_addr.size() - n0); end
  endtask

  task automatic test_single();
    int c0, n0;
    apply_reset();
    i_free_vbus_b = 1'b0;
    cpu_write(2'd0, 8'h34, c0);
    cpu_write(2'd1, 8'h12, c0);
    n0 = s_addr.size();
    cpu_write(2'd2, 8'hAA, c0);
    step(4);
    checks++;
    if (s_addr.size() - n0 !== 1) begin
      errors++; $display("FAIL single_count: got %0d strobes want 1", s_addr.size() - n0);
    end else begin
      checks++; if (s_addr[n0] !== 16'h1234) begin errors++; $display("FAIL single_addr: got %h want 1234", s_addr[n0]); end
      checks++; if (s_data[n0] !== 8'hAA) begin errors++; $display("FAIL single_data: got %h want aa", s_data[n0]); end
      checks++; if (s_en[n0] !== 1'b0) begin errors++; $display("FAIL single_bus_en: got %b want 0", s_en[n0]); end
      checks++; if (s_cyc[n0] - c0 !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", s_cyc[n0] - c0); end
    end
    checks++; if (o_vaddr !== 16'h1234) begin errors++; $display("FAIL single_hold_addr: got %h want 1234", o_vaddr); end
    checks++; if (o_vbus_en_b !== 1'b1) begin errors++; $display("FAIL single_released: got %b want 1", o_vbus_en_b); end
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL single_idle_b: got %b want 0", o_idle_b); end
    n0 = s_addr.size();
    cpu_write(2'd2, 8'hBB, c0);
    step(4);
    checks++;
    if (s_addr.size() - n0 !== 1) begin
      errors++; $display("FAIL second_count: got %0d strobes want 1", s_addr.size() - n0);
    end else if (s_addr[n0] !== (AutoInc ? 16'h1235 : 16'h1234)) begin
      errors++; $display("FAIL second_addr: got %h want %h", s_addr[n0], AutoInc ? 16'h1235 : 16'h1234);
    end
  endtask

  task automatic test_overflow();
    int c0, n0;
    apply_reset();
    i_free_vbus_b = 1'b1;
    cpu_write(2'd0, 8'h00, c0);
    cpu_write(2'd1, 8'h01, c0);
    n0 = s_addr.size();
    for (int i = 0; i < 5; i++) cpu_write(2'd2, 8'(8'h10 + i), c0);
    checks++; if (o_fifo_full_b !== 1'b0) begin errors++; $display("FAIL ovf_full_b: got %b want 0", o_fifo_full_b); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
    checks++; if (o_idle_b !== 1'b1) begin errors++; $display("FAIL ovf_idle_b: got %b want 1", o_idle_b); end
    checks++; if (s_addr.size() - n0 !== 0) begin errors++; $display("FAIL ovf_no_strobe: got %0d want 0", s_addr.size() - n0); end
    i_free_vbus_b = 1'b0;
    step(24);
    checks++;
    if (s_addr.size() - n0 !== 4) begin
      errors++; $display("FAIL drain_count: got %0d strobes want 4", s_addr.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (s_data[n0+i] !== 8'(8'h10 + i)) begin
          errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_data[n0+i], 8'(8'h10 + i));
        end
        checks++;
        if (s_addr[n0+i] !== (AutoInc ? 16'(16'h0100 + i) : 16'h0100)) begin
          errors++; $display("FAIL drain_addr[%0d]: got %h want %h", i, s_addr[n0+i],
                             AutoInc ? 16'(16'h0100 + i) : 16'h0100);
        end
        if (i > 0) begin
          checks++;
          if (s_cyc[n0+i] - s_cyc[n0+i-1] !== 4) begin
            errors++; $display("FAIL drain_spacing[%0d]: got %0d want 4", i, s_cyc[n0+i] - s_cyc[n0+i-1]);
          end
        end
      end
    end
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL drain_idle_b: got %b want 0", o_idle_b); end
    checks++; if (o_fifo_full_b !== 1'b1) begin errors++; $display("FAIL drain_full_b: got %b want 1", o_fifo_full_b); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
    cpu_write(2'd3, 8'h01, c0);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
  endtask

  task automatic test_wrap();
    int c0, n0;
    logic [15:0] exp [3];
    apply_reset();
    i_free_vbus_b = 1'b0;
    cpu_write(2'd0, 8'hFF, c0);
    cpu_write(2'd1, 8'hFF, c0);
    n0 = s_addr.size();
    cpu_write(2'd2, 8'h01, c0);
    cpu_write(2'd2, 8'h02, c0);
    cpu_write(2'd2, 8'h03, c0);
    step(8);
    exp[0] = 16'hFFFF;
    exp[1] = AutoInc ? 16'h0000 : 16'hFFFF;
    exp[2] = AutoInc ? 16'h0001 : 16'hFFFF;
    checks++;
    if (s_addr.size() - n0 !== 3) begin
      errors++; $display("FAIL wrap_count: got %0d strobes want 3", s_addr.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (s_addr[n0+i] !== exp[i]) begin
          errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, s_addr[n0+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_bus_release();
    int c0, n0;
    bit found;
    apply_reset();
    i_free_vbus_b = 1'b1;
    cpu_write(2'd2, 8'h55, c0);
    cpu_write(2'd2, 8'h66, c0);
    n0 = s_addr.size();
    i_free_vbus_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (o_vwe_b === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL release_strobe_seen: got none want strobe within 20 clk");
    end
    i_free_vbus_b = 1'b1;
    step(1);
    checks++; if (o_vwe_b !== 1'b1) begin errors++; $display("FAIL release_hold_vwe_b: got %b want 1", o_vwe_b); end
    checks++; if (o_vbus_en_b !== 1'b0) begin errors++; $display("FAIL release_hold_en_b: got %b want 0", o_vbus_en_b); end
    step(1);
    checks++; if (o_vbus_en_b !== 1'b1) begin errors++; $display("FAIL release_idle_en_b: got %b want 1", o_vbus_en_b); end
    step(10);
    checks++; if (s_addr.size() - n0 !== 1) begin errors++; $display("FAIL release_no_new: got %0d strobes want 1", s_addr.size() - n0); end
    checks++; if (o_idle_b !== 1'b1) begin errors++; $display("FAIL release_pending: got %b want 1", o_idle_b); end
    i_free_vbus_b = 1'b0;
    step(10);
    checks++;
    if (s_addr.size() - n0 !== 2) begin
      errors++; $display("FAIL release_resume: got %0d strobes want 2", s_addr.size() - n0);
    end else if (s_data[n0+1] !== 8'h66) begin
      errors++; $display("FAIL release_resume_data: got %h want 66", s_data[n0+1]);
    end
  endtask

  task automatic test_reset_mid();
    int c0, n0;
    bit found;
    apply_reset();
    i_free_vbus_b = 1'b1;
    cpu_write(2'd2, 8'h77, c0);
    cpu_write(2'd2, 8'h88, c0);
    i_free_vbus_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (o_vwe_b === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_strobe_seen: got none want strobe within 20 clk");
    end
    n0 = s_addr.size();
    i_rst = 1'b1;
    #1;
    checks++; if (o_vwe_b !== 1'b1) begin errors++; $display("FAIL rstmid_vwe_b: got %b want 1", o_vwe_b); end
    checks++; if (o_vbus_en_b !== 1'b1) begin errors++; $display("FAIL rstmid_en_b: got %b want 1", o_vbus_en_b); end
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b want 0", o_idle_b); end
    step(2);
    i_rst = 1'b0;
    step(15);
    checks++; if (s_addr.size() - n0 !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d strobes want 0", s_addr.size() - n0); end
  endtask

  task automatic test_flush();
    int c0, n0;
    apply_reset();
    i_free_vbus_b = 1'b1;
    for (int i = 0; i < 5; i++) cpu_write(2'd2, 8'(8'h20 + i), c0);
    cpu_write(2'd3, 8'h02, c0);
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", o_idle_b); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf: got %b want 1", o_overflow); end
    cpu_write(2'd2, 8'h31, c0);
    cpu_write(2'd2, 8'h32, c0);
    checks++; if (o_idle_b !== 1'b1) begin errors++; $display("FAIL flush_two_queued: got %b want 1", o_idle_b); end
    cpu_write(2'd3, 8'h03, c0);
    checks++; if (o_idle_b !== 1'b0) begin errors++; $display("FAIL flush_clear_empty: got %b want 0", o_idle_b); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL flush_clear_ovf: got %b want 0", o_overflow); end
    n0 = s_addr.size();
    i_free_vbus_b = 1'b0;
    step(10);
    checks++; if (s_addr.size() - n0 !== 0) begin errors++; $display("FAIL flush_no_write: got %0d strobes want 0", s_addr.size() - n0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_wrap();
    test_bus_release();
    test_reset_mid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
